// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressed data memory for the load/store stage.
//
// Accepts one request at a time over a valid/ready handshake. Each request is
// either a store (SB/SH/SW) or a load (LB/LH/LW/LBU/LHU). Its response is held
// until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_funct3            RV32 size code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr              byte address; word index taken from the low bits
//   req_wdata             right-justified store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data; 0 for stores and errors
//   rsp_err               misaligned, illegal funct3 or out-of-range request
//
// Configuration macro: DMEM_BOUNDS_CHECK_EN
//   defined   - addresses >= 4*DEPTH_WORDS return an error and write nothing
//   undefined - addresses wrap modulo 4*DEPTH_WORDS
module dmem_unit #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
    // The wait counter only has to hold READ_LATENCY-2.
    localparam int unsigned CntW  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [AddrW-1:0] word_idx;
    logic [1:0]       byte_off;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic             f3_legal;
    logic             misaligned;
    logic             out_of_range;
    logic             req_err;
    logic             accept;
    logic [3:0]       lane_mask;
    logic [31:0]      lane_data;
    logic [31:0]      load_data;
    logic [3:0]       wr_be;

    assign word_idx = req_addr[2 +: AddrW];
    assign byte_off = req_addr[1:0];
    assign rd_word  = mem_q[word_idx];
    assign rd_byte  = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half  = rd_word[{byte_off[1], 4'b0000} +: 16];
    // Reset wins over a request presented in the same cycle.
    assign accept   = req_valid & req_ready_q & rst_n;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign out_of_range = (req_addr >= 32'(4 * DEPTH_WORDS));
`else
    assign out_of_range = 1'b0;
    // Upper address bits are deliberately ignored: the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AddrW+2];
`endif

    // Size decode: lane enables, replicated store data and extended load data.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        lane_mask  = 4'b0000;
        lane_data  = 32'h0;
        load_data  = 32'h0;
        case (req_funct3)
            3'b000, 3'b100: begin
                f3_legal  = ~(req_we & req_funct3[2]);
                lane_mask = 4'b0001 << byte_off;
                lane_data = {4{req_wdata[7:0]}};
                load_data = req_funct3[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            3'b001, 3'b101: begin
                f3_legal   = ~(req_we & req_funct3[2]);
                misaligned = byte_off[0];
                lane_mask  = 4'b0011 << {byte_off[1], 1'b0};
                lane_data  = {2{req_wdata[15:0]}};
                load_data  = req_funct3[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            3'b010: begin
                f3_legal   = 1'b1;
                misaligned = (byte_off != 2'b00);
                lane_mask  = 4'b1111;
                lane_data  = req_wdata;
                load_data  = rd_word;
            end
            default: f3_legal = 1'b0;
        endcase
    end

    assign req_err = ~f3_legal | misaligned | out_of_range;
    assign wr_be   = (accept & req_we & ~req_err) ? lane_mask : 4'b0000;

    // RAM contents are not reset; a store commits on its accept edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem_q[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    rsp_err_d   = req_err;
                    // Load data is sampled at accept; only its release is delayed.
                    rsp_rdata_d = (req_we || req_err) ? 32'h0 : load_data;
                    if (!req_we && !req_err && READ_LATENCY > 1) begin
                        state_d = StWait;
                        cnt_d   = CntW'(READ_LATENCY - 2);
                    end else begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
